ins_fetch: RTL

Instruction fetch stage of the multi-cycle CPU. On a fetch request from the stage sequencer it latches the current program-counter value `ins_address`, performs one read on the instruction-memory port using a request/ready/rvalid handshake, and holds the returned word in an instruction register. It drives the `opcode` and `imm_ext` fields that the program-counter and execute stages consume, and reports completion, misalignment and timeout.

---
 rtl/ins_fetch_if.sv | 24 ++
 rtl/ins_fetch.sv | 130 +++++++++++++
 2 files changed

// File: rtl/ins_fetch_if.sv
// Instruction-memory read port: request/ready handshake plus rvalid-qualified read data.
interface ins_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/ins_fetch.sv
// Instruction fetch stage: one memory read per fetch_start, with misalignment and
// timeout detection; the returned word is held in the instruction register.
module ins_fetch #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       ins_address,
  input  logic              fetch_start,
  ins_fetch_if.master       imem,
  output logic [31:0]       instr,
  output logic [4:0]        opcode,
  output logic [31:0]       imm_ext,
  output logic              fetch_done,
  output logic              fetch_err,
  output logic              busy
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [31:0]   addr_r, addr_s;
  logic [31:0]   instr_r, instr_s;
  logic          err_r, err_s;
  logic          done_r, done_s;
  logic          req_r, busy_r;

  // Next-state, counter and datapath decisions for the fetch sequence.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    addr_s  = addr_r;
    instr_s = instr_r;
    err_s   = err_r;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (fetch_start) begin
          if (ins_address[1:0] == 2'b00) begin
            addr_s  = ins_address;
            err_s   = 1'b0;
            cnt_s   = '0;
            state_s = REQ;
          end else begin
            err_s  = 1'b1;
            done_s = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        // Ready and rvalid together complete the fetch without visiting WAIT.
        if (imem.imem_ready && imem.imem_rvalid) begin
          instr_s = imem.imem_rdata;
          done_s  = 1'b1;
          state_s = IDLE;
        end else if (cnt_r == CNT_LAST) begin
          instr_s = 32'h0000_0000;
          err_s   = 1'b1;
          done_s  = 1'b1;
          state_s = IDLE;
        end else begin
          cnt_s   = cnt_r + CNT_ONE;
          state_s = imem.imem_ready ? WAIT : REQ;
        end
      end
      WAIT: begin
        if (imem.imem_rvalid) begin
          instr_s = imem.imem_rdata;
          done_s  = 1'b1;
          state_s = IDLE;
        end else if (cnt_r == CNT_LAST) begin
          instr_s = 32'h0000_0000;
          err_s   = 1'b1;
          done_s  = 1'b1;
          state_s = IDLE;
        end else begin
          cnt_s   = cnt_r + CNT_ONE;
          state_s = WAIT;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers; req/busy are decoded from the next state so they stay registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      addr_r  <= 32'h0000_0000;
      instr_r <= 32'h0000_0000;
      err_r   <= 1'b0;
      done_r  <= 1'b0;
      req_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      addr_r  <= addr_s;
      instr_r <= instr_s;
      err_r   <= err_s;
      done_r  <= done_s;
      req_r   <= (state_s == REQ);
      busy_r  <= (state_s != IDLE);
    end
  end

  assign imem.imem_req  = req_r;
  assign imem.imem_addr = addr_r;
  assign instr          = instr_r;
  assign opcode         = instr_r[31:27];
  assign imm_ext        = {{16{instr_r[15]}}, instr_r[15:0]};
  assign fetch_done     = done_r;
  assign fetch_err      = err_r;
  assign busy           = busy_r;

endmodule
